// File: rtl/sram_arb_2to1.sv
// sram_arb_2to1: merges the inst and data SRAM-like master ports onto one memory port.
// A grant FSM picks a master (data over inst, or round-robin when SRAM_ARB_RR_EN is
// defined) and holds the grant until the memory accepts the address. A 1-bit ID FIFO
// records acceptance order so that in-order responses are steered back to their owner.
module sram_arb_2to1 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // inst master
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data master
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // memory side
  output logic        mem_sram_req,
  output logic        mem_sram_wr,
  output logic [1:0]  mem_sram_size,
  output logic [3:0]  mem_sram_wstrb,
  output logic [31:0] mem_sram_addr,
  output logic [31:0] mem_sram_wdata,
  input  logic        mem_sram_addr_ok,
  input  logic        mem_sram_data_ok,
  input  logic [31:0] mem_sram_rdata
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_I = 2'd1,
    S_LOCK_D = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] id_mem_q, id_mem_d;   // 0 = inst, 1 = data

  logic grant_data;   // 1: data master owns the memory port this cycle
  logic tie_data;     // 1: data wins when both masters request in IDLE
  logic full, empty, push, pop, head_id;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q, last_grant_d;   // 0 = inst was last accepted, 1 = data
  assign tie_data = ~last_grant_q;
`else
  assign tie_data = 1'b1;
`endif

  // Grant selection: fixed while locked, otherwise arbitrated combinationally.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_data = 1'b0;
    case (state_q)
      S_LOCK_I: grant_data = 1'b0;
      S_LOCK_D: grant_data = 1'b1;
      default:  grant_data = data_sram_req & (~inst_sram_req | tie_data);
    endcase
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Request passthrough; resetn gating keeps handshakes quiet while reset is asserted.
  assign mem_sram_req   = resetn & ~full & (grant_data ? data_sram_req : inst_sram_req);
  assign mem_sram_wr    = grant_data ? data_sram_wr    : inst_sram_wr;
  assign mem_sram_size  = grant_data ? data_sram_size  : inst_sram_size;
  assign mem_sram_wstrb = grant_data ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_sram_addr  = grant_data ? data_sram_addr  : inst_sram_addr;
  assign mem_sram_wdata = grant_data ? data_sram_wdata : inst_sram_wdata;

  assign inst_sram_addr_ok = resetn & ~full & ~grant_data & mem_sram_addr_ok;
  assign data_sram_addr_ok = resetn & ~full &  grant_data & mem_sram_addr_ok;

  // A response arriving with nothing outstanding is dropped.
  assign push    = mem_sram_req & mem_sram_addr_ok;
  assign pop     = mem_sram_data_ok & ~empty;
  assign head_id = id_mem_q[rd_ptr_q];

  assign inst_sram_data_ok = resetn & pop & ~head_id;
  assign data_sram_data_ok = resetn & pop &  head_id;
  assign inst_sram_rdata   = mem_sram_rdata;
  assign data_sram_rdata   = mem_sram_rdata;

  // Grant FSM next state: lock onto the presented master until its address is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_sram_req && !mem_sram_addr_ok) begin
          state_d = grant_data ? S_LOCK_D : S_LOCK_I;
        end
      end
      S_LOCK_I, S_LOCK_D: begin
        if (mem_sram_addr_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Order FIFO next state: pointers wrap naturally because the depth is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    id_mem_d = id_mem_q;
    if (push) begin
      id_mem_d[wr_ptr_q] = grant_data;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin history: remember who got the last accepted request.
  always_comb begin
    last_grant_d = push ? grant_data : last_grant_q;
  end
`endif

  // Control state: FSM, pointers and occupancy count.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // ID storage: only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    // NOTE: the ID array is left unreset; count_q qualifies every read, so stale contents are harmless.
    id_mem_q <= id_mem_d;
  end

endmodule
